// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared op/state encodings and widths for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_access_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FADD  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage : mem_access_pkg

`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store/fetch-and-add sequencer for a 256x8 data memory
//               with one-cycle registered read. Define MEM_ACCESS_FADD_EN to
//               enable fetch-and-add; otherwise FADD returns an error.
// Revision    : 1.0 - initial release
// ============================================================================

import mem_access_pkg::*;

module mem_access_unit (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata
);

    state_t r_state;
`ifdef MEM_ACCESS_FADD_EN
    logic   r_is_fadd;
`endif

    // mem_address / mem_writedata double as the latched request registers;
    // for FADD, mem_writedata holds the addend until the sum replaces it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
`ifdef MEM_ACCESS_FADD_EN
            r_is_fadd     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready     <= 1'b0;
                        mem_address   <= req_addr;
                        mem_writedata <= req_wdata;
                        resp_data     <= '0;
                        resp_err      <= 1'b0;
`ifdef MEM_ACCESS_FADD_EN
                        r_is_fadd     <= 1'b0;
`endif
                        case (op_t'(req_op))
                            OP_LOAD: begin
                                mem_read <= 1'b1;
                                r_state  <= RD;
                            end
                            OP_STORE: begin
                                mem_write <= 1'b1;
                                r_state   <= WR;
                            end
                            OP_FADD: begin
`ifdef MEM_ACCESS_FADD_EN
                                r_is_fadd <= 1'b1;
                                mem_read  <= 1'b1;
                                r_state   <= RD;
`else
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                                r_state    <= RESP;
`endif
                            end
                            default: begin
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                                r_state    <= RESP;
                            end
                        endcase
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    resp_data <= mem_readdata;
`ifdef MEM_ACCESS_FADD_EN
                    // Write follows the read directly, so nothing can interleave.
                    if (r_is_fadd) begin
                        mem_writedata <= mem_readdata + mem_writedata;
                        mem_write     <= 1'b1;
                        r_state       <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
`else
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
`endif
                end
                WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_access_unit

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               256x8 registered-read memory model alongside.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_access_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_data;
    logic       resp_err;
    logic [7:0] mem_address;
    logic [7:0] mem_writedata;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_readdata;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int both_cnt = 0;
    int last_wr = -1;
    int acc_cyc = 0;

    mem_access_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_readdata  (mem_readdata)
    );

    always #5 CLK = ~CLK;

    // Data memory: one-cycle registered read, synchronous write.
    always @(posedge CLK) begin
        if (mem_write) mem[mem_address] <= mem_writedata;
        if (mem_read)  mem_readdata <= mem[mem_address];
    end

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (mem_read) rd_cnt = rd_cnt + 1;
        if (mem_write) begin
            wr_cnt  = wr_cnt + 1;
            last_wr = cyc;
        end
        if (mem_read && mem_write) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge and return just after its accept edge.
    task automatic accept(input string tag, input logic [1:0] op,
                          input logic [7:0] addr, input logic [7:0] wd);
        int w;
        w = 0;
        @(negedge CLK);
        while (!req_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge CLK);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // Returns at the negedge of the first cycle with resp_valid high.
    task automatic do_req(input string tag, input logic [1:0] op,
                          input logic [7:0] addr, input logic [7:0] wd,
                          input int exp_lat, input logic [7:0] exp_data,
                          input logic exp_err);
        int k;
        bit seen;
        accept(tag, op, addr, wd);
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge CLK);
            k++;
            if (resp_valid) seen = 1;
        end
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_err"}, resp_err, exp_err);
    endtask

    initial begin
        int rd0, wr0, acc1;
        logic [7:0] held;
        logic [1:0] rst_op;
        logic [7:0] rst_orig;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'h3C;
        mem[8'hFF] = 8'hC3;
        mem[8'h20] = 8'hF0;

        // Reset values
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 8'h00);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 8'h00);
        chk("rst_mem_writedata", mem_writedata, 8'h00);
        RESET = 1'b1;

        // STORE 0x5A -> 0x10, then LOAD it back
        wr0 = wr_cnt;
        do_req("store", 2'b01, 8'h10, 8'h5A, 2, 8'h00, 1'b0);
        chk("store_write_edge", last_wr - acc_cyc, 1);
        chk("store_write_count", wr_cnt - wr0, 1);
        chk("store_mem", mem[8'h10], 8'h5A);
        do_req("load", 2'b00, 8'h10, 8'h00, 3, 8'h5A, 1'b0);

        // FADD with wraparound
        rd0 = rd_cnt;
        wr0 = wr_cnt;
`ifdef MEM_ACCESS_FADD_EN
        do_req("fadd", 2'b10, 8'h20, 8'h20, 4, 8'hF0, 1'b0);
        chk("fadd_mem", mem[8'h20], 8'h10);
        chk("fadd_reads", rd_cnt - rd0, 1);
        chk("fadd_writes", wr_cnt - wr0, 1);
`else
        do_req("fadd", 2'b10, 8'h20, 8'h20, 1, 8'h00, 1'b1);
        chk("fadd_mem", mem[8'h20], 8'hF0);
        chk("fadd_reads", rd_cnt - rd0, 0);
        chk("fadd_writes", wr_cnt - wr0, 0);
`endif

        // Reserved op
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_req("rsvd", 2'b11, 8'h44, 8'h99, 1, 8'h00, 1'b1);
        @(negedge CLK);
        chk("rsvd_reads", rd_cnt - rd0, 0);
        chk("rsvd_writes", wr_cnt - wr0, 0);

        // Stall with resp_ready low; a second request must not be taken
        resp_ready = 1'b0;
        do_req("stall_load", 2'b00, 8'h33, 8'h00, 3, 8'h33 ^ 8'hA5, 1'b0);
        held = resp_data;
        rd0  = rd_cnt;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 8'h34;
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            chk("stall_valid", resp_valid, 1);
            chk("stall_data", resp_data, held);
            chk("stall_req_ready", req_ready, 0);
        end
        chk("stall_no_accept", rd_cnt - rd0, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("stall_released", resp_valid, 0);
        chk("stall_idle", req_ready, 1);

        // Reset asserted during the first memory cycle of an operation
`ifdef MEM_ACCESS_FADD_EN
        rst_op = 2'b10;
`else
        rst_op = 2'b01;
`endif
        rst_orig = mem[8'h50];
        wr0 = wr_cnt;
        accept("rst_mid", rst_op, 8'h50, 8'h07);
        @(negedge CLK);
`ifdef MEM_ACCESS_FADD_EN
        chk("rst_mid_in_rd", mem_read, 1);
`else
        chk("rst_mid_in_wr", mem_write, 1);
`endif
        RESET = 1'b0;
        #1;
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_mem_read", mem_read, 0);
        chk("rst_mid_mem_write", mem_write, 0);
        chk("rst_mid_mem_address", mem_address, 8'h00);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        chk("rst_mid_no_write", wr_cnt - wr0, 0);
        chk("rst_mid_mem", mem[8'h50], rst_orig);
        do_req("post_rst_load", 2'b00, 8'h50, 8'h00, 3, rst_orig, 1'b0);

        // Back-to-back loads, resp_ready tied high
        do_req("b2b_load0", 2'b00, 8'h00, 8'h00, 3, 8'h3C, 1'b0);
        acc1 = acc_cyc;
        do_req("b2b_loadff", 2'b00, 8'hFF, 8'h00, 3, 8'hC3, 1'b0);
        chk("b2b_spacing", acc_cyc - acc1, 4);

        @(negedge CLK);
        chk("never_read_and_write", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_access_unit

`default_nettype wire
